// File: rtl/cordic_pkg.sv
// Shared widths, mode codes and FSM state type for the CORDIC job scheduler.
package cordic_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned MODE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RSP_W  = 2 * DATA_W;

  localparam logic [MODE_W-1:0] MODE_SINCOS   = 8'd1;
  localparam logic [MODE_W-1:0] MODE_SINHCOSH = 8'd2;
  localparam logic [MODE_W-1:0] MODE_TANH     = 8'd3;
  localparam logic [MODE_W-1:0] MODE_ASINACOS = 8'd4;
  localparam logic [MODE_W-1:0] MODE_EXP      = 8'd5;
  localparam logic [MODE_W-1:0] MODE_LN       = 8'd6;
  localparam logic [MODE_W-1:0] MODE_SQRT     = 8'd7;
  localparam logic [MODE_W-1:0] MODE_ARCTAN   = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALL,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic mode_valid(input logic [MODE_W-1:0] m);
    return (m >= MODE_SINCOS) && (m <= MODE_ARCTAN);
  endfunction

  // Modes whose engine produces a meaningful secondary result.
  function automatic logic mode_dual(input logic [MODE_W-1:0] m);
    return (m >= MODE_SINCOS) && (m <= MODE_ASINACOS);
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Four-way round-robin arbiter: searches from last_grant+1 and returns a one-hot grant.
module cordic_rr_arbiter
  import cordic_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      // Index arithmetic wraps modulo N_REQ through the ID_W-bit truncation.
      idx = last_grant + ID_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_job_scheduler.sv
// Arbitrates four requesters onto one shared CORDIC engine and returns one response per job.
// Optional WAIT-state timeout enabled with `define CORDIC_TIMEOUT_EN.
module cordic_job_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*MODE_W-1:0]   req_mode,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic                      eng_call,
  output logic [MODE_W-1:0]         eng_mode,
  output logic [DATA_W-1:0]         eng_a,
  output logic [DATA_W-1:0]         eng_b,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_res0,
  input  logic [DATA_W-1:0]         eng_res1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RSP_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [MODE_W-1:0] job_mode;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic              timeout_hit;
  logic [ID_W-1:0]   sel_id;
  logic [MODE_W-1:0] sel_mode;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  cordic_rr_arbiter u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel_id   = '0;
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_id   = ID_W'(i);
        sel_mode = req_mode[i*MODE_W +: MODE_W];
        sel_a    = req_a[i*DATA_W +: DATA_W];
        sel_b    = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CORDIC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a done in that same cycle wins.
  assign timeout_hit = (state == ST_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT && !eng_done && !timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 2'd3;
      job_mode   <= '0;
      eng_call   <= 1'b0;
      eng_mode   <= '0;
      eng_a      <= '0;
      eng_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= sel_id;
            rsp_id     <= sel_id;
            job_mode   <= sel_mode;
            busy       <= 1'b1;
            if (mode_valid(sel_mode)) begin
              eng_mode <= sel_mode;
              eng_a    <= sel_a;
              eng_b    <= (sel_mode == MODE_ARCTAN) ? sel_b : '0;
              eng_call <= 1'b1;
              state    <= ST_CALL;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end
          end
        end
        ST_CALL: state <= ST_WAIT;
        ST_WAIT: begin
          if (eng_done) begin
            eng_call  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= mode_dual(job_mode) ? {eng_res1, eng_res0}
                                             : {{DATA_W{1'b0}}, eng_res0};
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            eng_call  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Self-checking bench for cordic_job_scheduler: directed table, hand-written corner sequences
// and randomized jobs checked against a round-robin / result-packing reference model.
module tb_cordic_job_scheduler;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [31:0]   req_mode;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic          eng_call;
  logic [7:0]    eng_mode;
  logic [31:0]   eng_a;
  logic [31:0]   eng_b;
  logic          eng_done;
  logic [31:0]   eng_res0;
  logic [31:0]   eng_res1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] model_ptr;

  cordic_job_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_a     (req_a),
    .req_b     (req_b),
    .eng_call  (eng_call),
    .eng_mode  (eng_mode),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_done  (eng_done),
    .eng_res0  (eng_res0),
    .eng_res1  (eng_res1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] r0;
    logic [31:0] r1;
    int          bp;
    logic        exp_call;
    logic [31:0] exp_engb;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    eng_done  = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ptr = 2'd3;
  endtask

  // Reference arbiter: first set bit scanning upward from ptr+1, wrapping at 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(ptr) + k) % 4;
      if (mask[idx]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  function automatic logic [63:0] ref_data(input logic [7:0] m, input logic [31:0] r0,
                                           input logic [31:0] r1);
    if (m < 1 || m > 8) return 64'h0;
    if (m <= 4) return {r1, r0};
    return {32'h0, r0};
  endfunction

  task automatic set_lane(input int i, input logic [7:0] m, input logic [31:0] a,
                          input logic [31:0] b);
    req_mode[i*8 +: 8]  = m;
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
  endtask

  task automatic do_job(input logic [3:0] mask, input int lat, input logic [31:0] r0,
                        input logic [31:0] r1, input int bp, input logic [1:0] exp_id,
                        input logic exp_call, input logic [31:0] exp_engb,
                        input logic [63:0] exp_data, input logic exp_err);
    logic [7:0]  lm;
    logic [31:0] la;
    lm = req_mode[int'(exp_id)*8 +: 8];
    la = req_a[int'(exp_id)*32 +: 32];
    req_valid = mask;
    #1;
    chk("grant", {60'h0, req_ready}, {60'h0, 4'b0001 << exp_id});
    step();
    model_ptr = exp_id;
    chk("busy_after_accept", {63'h0, busy}, 64'h1);
    chk("no_grant_busy", {60'h0, req_ready}, 64'h0);
    if (exp_call) begin
      chk("eng_call_rise", {63'h0, eng_call}, 64'h1);
      chk("eng_mode", {56'h0, eng_mode}, {56'h0, lm});
      chk("eng_a", {32'h0, eng_a}, {32'h0, la});
      chk("eng_b", {32'h0, eng_b}, {32'h0, exp_engb});
      step();
      for (int k = 1; k < lat; k++) begin
        chk("eng_call_hold", {63'h0, eng_call}, 64'h1);
        step();
      end
      chk("eng_call_hold", {63'h0, eng_call}, 64'h1);
      eng_done = 1'b1;
      eng_res0 = r0;
      eng_res1 = r1;
      step();
      eng_done = 1'b0;
      eng_res0 = $urandom;
      eng_res1 = $urandom;
    end
    chk("eng_call_low", {63'h0, eng_call}, 64'h0);
    chk("rsp_valid", {63'h0, rsp_valid}, 64'h1);
    chk("rsp_id", {62'h0, rsp_id}, {62'h0, exp_id});
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", {63'h0, rsp_err}, {63'h0, exp_err});
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin
        eng_done = 1'b1;
        eng_res0 = ~r0;
        eng_res1 = ~r1;
      end
      step();
      eng_done = 1'b0;
      chk("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
      chk("bp_rsp_data", rsp_data, exp_data);
      chk("bp_no_grant", {60'h0, req_ready}, 64'h0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("rsp_valid_drop", {63'h0, rsp_valid}, 64'h0);
    chk("busy_drop", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    reset    = 1'b1;
    req_mode = '0;
    req_a    = '0;
    req_b    = '0;
    eng_res0 = '0;
    eng_res1 = '0;

    tbl[0] = '{2'd2, 8'd1, 32'h0000_4000, 32'h0000_0055, 10, 32'h1111_1111, 32'h2222_2222, 0,
               1'b1, 32'h0, 64'h2222_2222_1111_1111, 1'b0};
    tbl[1] = '{2'd1, 8'd8, 32'd5, 32'd7, 3, 32'h0000_ABCD, 32'h0000_9999, 0,
               1'b1, 32'd7, 64'h0000_0000_0000_ABCD, 1'b0};
    tbl[2] = '{2'd3, 8'd5, 32'd5, 32'd7, 2, 32'h0000_1234, 32'hFFFF_FFFF, 0,
               1'b1, 32'h0, 64'h0000_0000_0000_1234, 1'b0};
    tbl[3] = '{2'd0, 8'd0, 32'h1, 32'h2, 1, 32'h0, 32'h0, 0,
               1'b0, 32'h0, 64'h0, 1'b1};
    tbl[4] = '{2'd2, 8'd9, 32'h3, 32'h4, 1, 32'h0, 32'h0, 1,
               1'b0, 32'h0, 64'h0, 1'b1};
    tbl[5] = '{2'd0, 8'd4, 32'h10, 32'h20, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5,
               1'b1, 32'h0, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0};
    tbl[6] = '{2'd3, 8'd7, 32'h99, 32'h77, 4, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2,
               1'b1, 32'h0, 64'h0000_0000_DEAD_BEEF, 1'b0};

    do_reset();

    chk("rst_req_ready", {60'h0, req_ready}, 64'h0);
    chk("rst_eng_call", {63'h0, eng_call}, 64'h0);
    chk("rst_eng_mode", {56'h0, eng_mode}, 64'h0);
    chk("rst_eng_a", {32'h0, eng_a}, 64'h0);
    chk("rst_eng_b", {32'h0, eng_b}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_rsp_id", {62'h0, rsp_id}, 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 8'($urandom_range(0, 255)), $urandom, $urandom);
      set_lane(int'(tbl[v].id), tbl[v].mode, tbl[v].a, tbl[v].b);
      do_job(4'b0001 << tbl[v].id, tbl[v].lat, tbl[v].r0, tbl[v].r1, tbl[v].bp, tbl[v].id,
             tbl[v].exp_call, tbl[v].exp_engb, tbl[v].exp_data, tbl[v].exp_err);
    end

    // Fairness from reset: all requesters held, response taken immediately.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 8'(i + 1), 32'(100 + i), 32'(200 + i));
    for (int n = 0; n < 5; n++) begin
      logic [1:0]  g;
      logic [7:0]  m;
      logic [31:0] r0;
      logic [31:0] r1;
      g  = 2'(n % 4);
      m  = req_mode[int'(g)*8 +: 8];
      r0 = $urandom;
      r1 = $urandom;
      do_job(4'hF, 2, r0, r1, 0, g, 1'b1, 32'h0, ref_data(m, r0, r1), 1'b0);
    end

    // Reset asserted mid-WAIT: engine call and job vanish immediately.
    set_lane(1, 8'd2, 32'h1234, 32'h0);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    step();
    chk("pre_rst_call", {63'h0, eng_call}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_call", {63'h0, eng_call}, 64'h0);
    chk("async_rst_valid", {63'h0, rsp_valid}, 64'h0);
    chk("async_rst_busy", {63'h0, busy}, 64'h0);
    step();
    reset = 1'b0;
    model_ptr = 2'd3;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    chk("post_rst_no_rsp", {63'h0, rsp_valid}, 64'h0);
    chk("post_rst_idle", {63'h0, busy}, 64'h0);
    req_valid = 4'hF;
    #1;
    chk("post_rst_grant0", {60'h0, req_ready}, 64'h1);
    req_valid = '0;

    // Engine that never answers.
    set_lane(1, 8'd7, 32'h55, 32'h66);
    req_valid = 4'b0010;
    #1;
    chk("silent_grant", {60'h0, req_ready}, 64'h2);
    step();
    req_valid = '0;
    model_ptr = 2'd1;
    chk("silent_call", {63'h0, eng_call}, 64'h1);
    step();
`ifdef CORDIC_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk("to_wait_call", {63'h0, eng_call}, 64'h1);
      chk("to_wait_valid", {63'h0, rsp_valid}, 64'h0);
      step();
    end
    chk("to_rsp_valid", {63'h0, rsp_valid}, 64'h1);
    chk("to_rsp_err", {63'h0, rsp_err}, 64'h1);
    chk("to_rsp_data", rsp_data, 64'h0);
    chk("to_call_low", {63'h0, eng_call}, 64'h0);
    chk("to_rsp_id", {62'h0, rsp_id}, 64'h1);
`else
    for (int k = 0; k < 40; k++) begin
      chk("nt_wait_call", {63'h0, eng_call}, 64'h1);
      chk("nt_wait_valid", {63'h0, rsp_valid}, 64'h0);
      step();
    end
    eng_done = 1'b1;
    eng_res0 = 32'h0BAD_F00D;
    eng_res1 = 32'h1357_9BDF;
    step();
    eng_done = 1'b0;
    chk("nt_rsp_valid", {63'h0, rsp_valid}, 64'h1);
    chk("nt_rsp_err", {63'h0, rsp_err}, 64'h0);
    chk("nt_rsp_data", rsp_data, 64'h0000_0000_0BAD_F00D);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("silent_done_idle", {63'h0, busy}, 64'h0);

    // Randomized jobs against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  mask;
      logic [1:0]  g;
      logic [7:0]  m;
      logic [31:0] r0;
      logic [31:0] r1;
      logic        ok;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 9);
        m = (r < 8) ? 8'(r + 1) : ((r == 8) ? 8'd0 : 8'($urandom_range(9, 255)));
        set_lane(i, m, $urandom, $urandom);
      end
      mask = 4'($urandom_range(1, 15));
      g  = rr_pick(model_ptr, mask);
      m  = req_mode[int'(g)*8 +: 8];
      ok = (m >= 1) && (m <= 8);
      r0 = $urandom;
      r1 = $urandom;
      do_job(mask, $urandom_range(1, 6), r0, r1, $urandom_range(0, 3), g, ok,
             (m == 8) ? req_b[int'(g)*32 +: 32] : 32'h0, ref_data(m, r0, r1), !ok);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
